// File: rtl/q_sweep_scheduler_pkg.sv
// Shared types and constants for the q-sweep scheduler: FSM encoding, H matrix geometry,
// q index width and a helper giving the most positive signed value of a given width.
package q_sweep_scheduler_pkg;

   localparam int DATA_W     = 32;
   localparam int MATRIX_DIM = 4;
   localparam int H_ELEMS    = MATRIX_DIM * MATRIX_DIM;
   localparam int ELEM_AW    = $clog2(H_ELEMS);
   localparam int QIDX_W     = 4;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      ISSUE,
      FEED,
      WAIT,
      NEXT,
      DONE
   } state_t;

   // Seed value for the running minimum, so the first real Dh always wins.
   function automatic logic [63:0] signed_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/q_sweep_scheduler_if.sv
// Bundle of the sweep control, H source stream, calc-block and result signals.
// The scheduler uses the master view; its environment uses the slave view.
interface q_sweep_scheduler_if #(
   parameter int N = q_sweep_scheduler_pkg::DATA_W
);
   logic                sweep_start;
   logic                sweep_busy;
   logic                sweep_done;
   logic                h_src_valid;
   logic                h_src_ready;
   logic [N-1:0]        h_src_r;
   logic [N-1:0]        h_src_i;
   logic                start_new_q;
   logic [3:0]          q_index;
   logic                H_in_valid;
   logic [N-1:0]        H_in_r;
   logic [N-1:0]        H_in_i;
   logic                q_calc_done;
   logic signed [N-1:0] Dh_in;
   logic                Dh_in_valid;
   logic [3:0]          best_q;
   logic signed [N-1:0] best_dh;
   logic                err_overrun;

   modport master (
      input  sweep_start, h_src_valid, h_src_r, h_src_i, q_calc_done, Dh_in, Dh_in_valid,
      output sweep_busy, sweep_done, h_src_ready, start_new_q, q_index,
             H_in_valid, H_in_r, H_in_i, best_q, best_dh, err_overrun
   );

   modport slave (
      output sweep_start, h_src_valid, h_src_r, h_src_i, q_calc_done, Dh_in, Dh_in_valid,
      input  sweep_busy, sweep_done, h_src_ready, start_new_q, q_index,
             H_in_valid, H_in_r, H_in_i, best_q, best_dh, err_overrun
   );
endinterface

// File: rtl/q_sweep_hbuf.sv
// 16-entry complex H buffer: one write port for capture, one registered read port for replay.
module q_sweep_hbuf
   import q_sweep_scheduler_pkg::*;
#(
   parameter int N = DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ELEM_AW-1:0] wr_addr,
   input  logic [N-1:0]       wr_r,
   input  logic [N-1:0]       wr_i,
   input  logic               rd_en,
   input  logic [ELEM_AW-1:0] rd_addr,
   output logic [N-1:0]       rd_r,
   output logic [N-1:0]       rd_i
);

   logic [N-1:0] mem_r [H_ELEMS];
   logic [N-1:0] mem_i [H_ELEMS];

   // Storage needs no reset: every entry is rewritten before a replay reads it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_r;
         mem_i[wr_addr] <= wr_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_r <= '0;
         rd_i <= '0;
      end else if (rd_en) begin
         rd_r <= mem_r[rd_addr];
         rd_i <= mem_i[rd_addr];
      end
   end

endmodule

// File: rtl/q_sweep_scheduler.sv
// Sweeps every q index through the Hq/Dh calc block, replaying a captured H and tracking argmin Dh.
// Optional WAIT watchdog enabled by defining Q_SWEEP_WATCHDOG_EN.
module q_sweep_scheduler
   import q_sweep_scheduler_pkg::*;
#(
   parameter int N           = DATA_W,
   parameter int Q_NUM       = 16,
   parameter int DH_PER_Q    = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input logic                 clk,
   input logic                 rst,
   q_sweep_scheduler_if.master bus
);

   localparam int                 DHC_W     = $clog2(DH_PER_Q + 1);
   localparam logic [ELEM_AW-1:0] LAST_ELEM = ELEM_AW'(H_ELEMS - 1);
   localparam logic [QIDX_W-1:0]  LAST_Q    = QIDX_W'(Q_NUM - 1);
   localparam logic [DHC_W-1:0]   DH_FULL   = DHC_W'(DH_PER_Q);
   localparam logic [DHC_W-1:0]   DH_LAST   = DHC_W'(DH_PER_Q - 1);
   localparam logic signed [N-1:0] DH_INIT  = N'(signed_max(N));

   state_t               state, next_state;
   logic [ELEM_AW-1:0]   cnt, rd_addr;
   logic [QIDX_W-1:0]    q, best_q;
   logic [DHC_W-1:0]     dh_cnt;
   logic                 done_seen;
   logic signed [N-1:0]  best_dh;
   logic                 err_overrun, sweep_busy, sweep_done, h_src_ready, start_new_q, H_in_valid;
   logic [N-1:0]         H_in_r, H_in_i;
   logic                 accept, cap_fire, collecting, dh_fire, dh_full, dh_accept;
   logic                 done_now, results_ok, wdog_expire, rd_en;

   assign accept     = (state == IDLE) && bus.sweep_start;
   assign cap_fire   = (state == CAPTURE) && bus.h_src_valid;
   assign collecting = (state == FEED) || (state == WAIT);
   assign dh_fire    = collecting && bus.Dh_in_valid;
   assign dh_full    = (dh_cnt == DH_FULL);
   assign dh_accept  = dh_fire && !dh_full;
   assign done_now   = done_seen || (collecting && bus.q_calc_done);
   assign results_ok = done_now && (dh_full || (dh_accept && dh_cnt == DH_LAST));

`ifdef Q_SWEEP_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES);
   logic [WD_W-1:0] wdog;

   assign wdog_expire = (state == WAIT) && !results_ok && (wdog == WD_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 wdog <= '0;
      else if (state == ISSUE) wdog <= '0;
      else if (state == WAIT)  wdog <= wdog + 1'b1;
   end
`else
   assign wdog_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Read address runs one element ahead so the registered buffer output lines up with H_in_valid.
   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      rd_addr    = '0;
      case (state)
         IDLE:    if (accept) next_state = CAPTURE;
         CAPTURE: if (cap_fire && cnt == LAST_ELEM) next_state = ISSUE;
         ISSUE:   next_state = FEED;
         FEED:    if (cnt == LAST_ELEM) next_state = WAIT;
         WAIT:    if (results_ok || wdog_expire) next_state = NEXT;
         NEXT:    next_state = (q == LAST_Q) ? DONE : ISSUE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      rd_en = (next_state == FEED);
      if (state == FEED) rd_addr = cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_busy  <= 1'b0;
         sweep_done  <= 1'b0;
         h_src_ready <= 1'b0;
         start_new_q <= 1'b0;
         H_in_valid  <= 1'b0;
         cnt         <= '0;
         q           <= '0;
      end else begin
         sweep_busy  <= next_state inside {CAPTURE, ISSUE, FEED, WAIT, NEXT};
         sweep_done  <= (next_state == DONE);
         h_src_ready <= (next_state == CAPTURE);
         start_new_q <= (next_state == ISSUE);
         H_in_valid  <= (next_state == FEED);
         if (accept || state == ISSUE)       cnt <= '0;
         else if (cap_fire || state == FEED) cnt <= cnt + 1'b1;
         if (accept)                             q <= '0;
         else if (state == NEXT && q != LAST_Q)  q <= q + 1'b1;
      end
   end

   // Per-q bookkeeping plus the running minimum; ties keep the earlier q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dh_cnt      <= '0;
         done_seen   <= 1'b0;
         best_dh     <= DH_INIT;
         best_q      <= '0;
         err_overrun <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            dh_cnt    <= '0;
            done_seen <= 1'b0;
         end else begin
            if (dh_accept)                       dh_cnt    <= dh_cnt + 1'b1;
            if (collecting && bus.q_calc_done)   done_seen <= 1'b1;
         end
         if (accept) begin
            best_dh <= DH_INIT;
            best_q  <= '0;
         end else if (dh_accept && (bus.Dh_in < best_dh)) begin
            best_dh <= bus.Dh_in;
            best_q  <= q;
         end
         if (accept)                                  err_overrun <= 1'b0;
         else if ((dh_fire && dh_full) || wdog_expire) err_overrun <= 1'b1;
      end
   end

   q_sweep_hbuf #(.N(N)) u_hbuf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cap_fire),
      .wr_addr (cnt),
      .wr_r    (bus.h_src_r),
      .wr_i    (bus.h_src_i),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_r    (H_in_r),
      .rd_i    (H_in_i)
   );

   assign bus.sweep_busy  = sweep_busy;
   assign bus.sweep_done  = sweep_done;
   assign bus.h_src_ready = h_src_ready;
   assign bus.start_new_q = start_new_q;
   assign bus.q_index     = q;
   assign bus.H_in_valid  = H_in_valid;
   assign bus.H_in_r      = H_in_r;
   assign bus.H_in_i      = H_in_i;
   assign bus.best_q      = best_q;
   assign bus.best_dh     = best_dh;
   assign bus.err_overrun = err_overrun;

endmodule

// File: tb/tb_q_sweep_scheduler.sv
// Directed bench for q_sweep_scheduler: a table of whole-sweep scenarios with hand-computed
// best_q/best_dh/err_overrun, plus hand sequences for reset values, idle inputs and reset mid-FEED.
module tb_q_sweep_scheduler;

   localparam int N  = 32;
   localparam int QN = 16;
   localparam logic signed [N-1:0] MAXV = 32'sh7FFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   q_sweep_scheduler_if #(.N(N)) bus ();

   q_sweep_scheduler #(.N(N), .Q_NUM(QN), .DH_PER_Q(4), .WDOG_CYCLES(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int                  scen;
      bit                  throttle;
      bit                  mid_start;
      logic [3:0]          exp_q;
      logic signed [N-1:0] exp_dh;
      bit                  exp_err;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   passes = 0;
   bit   mon_busy = 1'b0;
   int   gap_count = 0;
   int   done_total = 0;

   always @(negedge clk) begin
      if (mon_busy && !bus.sweep_busy) gap_count <= gap_count + 1;
      if (bus.sweep_done)              done_total <= done_total + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Calc-block model: Dh value returned for pulse j of index q in each scenario.
   function automatic logic signed [N-1:0] dhValue(input int scen, input int q, input int j);
      case (scen)
         0:       return N'((q <= 7) ? 100 - q : 200);
         1:       return N'(((q == 3) || (q == 9)) ? -5 + (3 - j) : 50 + q + (3 - j));
         2:       return N'((q <= 4) ? 500 - 10 * q : 600);
         default: return N'((q == 0) ? 10 : 100 + q);
      endcase
   endfunction

   // 0: 4 Dh then done; 1: done during FEED; 2: done with 4th Dh; 3: 5 Dh (overrun); 4: no done
   function automatic int qMode(input int scen, input int q);
      if (scen == 1)           return q % 3;
      if (scen == 2 && q == 2) return 3;
      if (scen == 3 && q == 0) return 4;
      return 0;
   endfunction

   task automatic clearInputs();
      bus.sweep_start = 1'b0;
      bus.h_src_valid = 1'b0;
      bus.h_src_r     = '0;
      bus.h_src_i     = '0;
      bus.q_calc_done = 1'b0;
      bus.Dh_in       = '0;
      bus.Dh_in_valid = 1'b0;
   endtask

   task automatic applyStimulus(input int scen, input bit throttle, input bit mid_start,
                                input int abort_q);
      int k, guard, m;
      bit fire, replay_ok;
      bus.sweep_start = 1'b1;
      tick();
      bus.sweep_start = 1'b0;
      mon_busy = 1'b1;
      k = 0;
      guard = 0;
      while (k < 16 && guard < 200) begin
         bus.h_src_valid = throttle ? (guard % 2 == 0) : 1'b1;
         bus.h_src_r     = bus.h_src_valid ? N'(k + 1) : N'(999);
         bus.h_src_i     = bus.h_src_valid ? N'(-(k + 1)) : N'(-999);
         fire = bus.h_src_valid && bus.h_src_ready;
         tick();
         if (fire) k++;
         guard++;
      end
      bus.h_src_valid = 1'b0;
      checkOutput("capture_beats", k, 16);
      for (int q = 0; q < QN; q++) begin
         guard = 0;
         while (bus.start_new_q !== 1'b1 && guard < 3000) begin
            tick();
            guard++;
         end
         checkOutput("start_new_q", bus.start_new_q, 1);
         checkOutput("q_index", bus.q_index, q);
         if (bus.start_new_q !== 1'b1) break;
         m = qMode(scen, q);
         replay_ok = (bus.H_in_valid === 1'b0);
         tick();
         for (int e = 0; e < 16; e++) begin
            if (bus.H_in_valid !== 1'b1 || bus.H_in_r !== N'(e + 1) || bus.H_in_i !== N'(-(e + 1)))
               replay_ok = 1'b0;
            if (q == abort_q && e == 5) begin
               rst = 1'b1;
               #1;
               checkOutput("rst_H_in_valid", bus.H_in_valid, 0);
               checkOutput("rst_sweep_busy", bus.sweep_busy, 0);
               checkOutput("rst_best_dh", bus.best_dh, MAXV);
               checkOutput("rst_best_q", bus.best_q, 0);
               mon_busy = 1'b0;
               clearInputs();
               return;
            end
            bus.q_calc_done = (m == 1 && e == 4);
            tick();
         end
         bus.q_calc_done = 1'b0;
         if (bus.H_in_valid !== 1'b0) replay_ok = 1'b0;
         checkOutput("replay_1_to_16", replay_ok, 1);
         if (mid_start && q == 5) begin
            bus.sweep_start = 1'b1;
            tick();
            bus.sweep_start = 1'b0;
         end
         for (int j = 0; j < 4; j++) begin
            bus.Dh_in_valid = 1'b1;
            bus.Dh_in       = dhValue(scen, q, j);
            bus.q_calc_done = (m == 2 && j == 3);
            tick();
         end
         bus.Dh_in_valid = 1'b0;
         bus.q_calc_done = 1'b0;
         if (m == 3) begin
            bus.Dh_in_valid = 1'b1;
            bus.Dh_in       = -32'sd1000;
            tick();
            bus.Dh_in_valid = 1'b0;
         end
         if (m == 0 || m == 3) begin
            bus.q_calc_done = 1'b1;
            tick();
            bus.q_calc_done = 1'b0;
         end
      end
      guard = 0;
      while (bus.sweep_done !== 1'b1 && guard < 3000) begin
         tick();
         guard++;
      end
      mon_busy = 1'b0;
      checkOutput("sweep_done_seen", bus.sweep_done, 1);
      checkOutput("busy_low_at_done", bus.sweep_busy, 0);
   endtask

   initial begin
      int d0, g0;
      clearInputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_sweep_busy", bus.sweep_busy, 0);
      checkOutput("reset_sweep_done", bus.sweep_done, 0);
      checkOutput("reset_h_src_ready", bus.h_src_ready, 0);
      checkOutput("reset_start_new_q", bus.start_new_q, 0);
      checkOutput("reset_H_in_valid", bus.H_in_valid, 0);
      checkOutput("reset_q_index", bus.q_index, 0);
      checkOutput("reset_best_q", bus.best_q, 0);
      checkOutput("reset_best_dh", bus.best_dh, MAXV);
      checkOutput("reset_err_overrun", bus.err_overrun, 0);
      rst = 1'b0;
      tick();

      bus.Dh_in_valid = 1'b1;
      bus.Dh_in       = -32'sd7;
      bus.q_calc_done = 1'b1;
      bus.h_src_valid = 1'b1;
      tick();
      tick();
      clearInputs();
      tick();
      checkOutput("idle_best_dh", bus.best_dh, MAXV);
      checkOutput("idle_err_overrun", bus.err_overrun, 0);
      checkOutput("idle_h_src_ready", bus.h_src_ready, 0);
      checkOutput("idle_sweep_busy", bus.sweep_busy, 0);

      vecs.push_back('{scen: 0, throttle: 1'b0, mid_start: 1'b0, exp_q: 4'd7, exp_dh: 93,   exp_err: 1'b0});
      vecs.push_back('{scen: 1, throttle: 1'b1, mid_start: 1'b1, exp_q: 4'd3, exp_dh: -5,   exp_err: 1'b0});
      vecs.push_back('{scen: 2, throttle: 1'b0, mid_start: 1'b0, exp_q: 4'd4, exp_dh: 460,  exp_err: 1'b1});
`ifdef Q_SWEEP_WATCHDOG_EN
      vecs.push_back('{scen: 3, throttle: 1'b0, mid_start: 1'b0, exp_q: 4'd0, exp_dh: 10,   exp_err: 1'b1});
`endif

      foreach (vecs[i]) begin
         d0 = done_total;
         g0 = gap_count;
         applyStimulus(vecs[i].scen, vecs[i].throttle, vecs[i].mid_start, -1);
         checkOutput("best_q", bus.best_q, vecs[i].exp_q);
         checkOutput("best_dh", bus.best_dh, vecs[i].exp_dh);
         checkOutput("err_overrun", bus.err_overrun, vecs[i].exp_err);
         repeat (4) tick();
         checkOutput("sweep_done_count", done_total - d0, 1);
         checkOutput("busy_gaps", gap_count - g0, 0);
         checkOutput("best_q_held", bus.best_q, vecs[i].exp_q);
         checkOutput("best_dh_held", bus.best_dh, vecs[i].exp_dh);
         checkOutput("idle_after_done", bus.sweep_busy, 0);
      end

      applyStimulus(0, 1'b0, 1'b0, 2);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post_rst_q_index", bus.q_index, 0);
      applyStimulus(0, 1'b0, 1'b0, -1);
      checkOutput("recover_best_q", bus.best_q, 7);
      checkOutput("recover_best_dh", bus.best_dh, 93);
      checkOutput("recover_err", bus.err_overrun, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
